sha256_block_seq: RTL and testbench
===================================

SHA256_BLOCK_SEQ -- requirements
Module: sha256_block_seq

Interface
REQ-001 SHALL have parameter ROUNDS, default 64: compression rounds per block.
REQ-002 SHALL have parameter MSG_WORDS, default 16: rounds whose message word comes from the input stream.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: request a new hash; sampled only in IDLE.
REQ-006 SHALL have port num_blocks, input, 2: block count for the hash, latched at start.
REQ-007 SHALL have port abort, input, 1: cancel the hash in progress.
REQ-008 SHALL have port w_valid, input, 1: message word available on the external word bus.
REQ-009 SHALL have port w_ready, output, 1: message word consumed this cycle.
REQ-010 SHALL have port block, output, 2: block index driven to the H0..H7 accumulators.
REQ-011 SHALL have port round, output, 6: current round index, 0..ROUNDS-1.
REQ-012 SHALL have port w_sel, output, 1: 0 selects the input word, 1 selects the schedule recurrence.
REQ-013 SHALL have port load_wv, output, 1: load working variables a..h from H0..H7.
REQ-014 SHALL have port round_en, output, 1: advance working variables one round.
REQ-015 SHALL have port accum, output, 1: H accumulators add working variables.
REQ-016 SHALL have port busy, output, 1: hash in progress.
REQ-017 SHALL have port done, output, 1: one-cycle pulse, digest valid in H0..H7.

Function
REQ-018 SHALL implement states IDLE, INIT, LOADWV, ROUND, ACCUM and DONE.
REQ-019 SHALL move IDLE->INIT when start=1, latching nblk = num_blocks, with 0 mapped to 1.
REQ-020 SHALL stay in INIT for 1 cycle with block=0, so the accumulators reload the IV, then go to LOADWV with blk=1.
REQ-021 SHALL stay in LOADWV for 1 cycle with load_wv=1, round=0, then go to ROUND.
REQ-022 In ROUND, for round<MSG_WORDS: w_sel=0, w_ready=round_en=w_valid; round increments only when w_valid=1; stall otherwise with all outputs held.
REQ-023 In ROUND, for round>=MSG_WORDS: w_sel=1, w_ready=0, round_en=1 every cycle, ignoring w_valid.
REQ-024 SHALL move ROUND->ACCUM after the round_en cycle at round=ROUNDS-1.
REQ-025 SHALL stay in ACCUM for 1 cycle with accum=1 and block=blk; then go to LOADWV with blk+1 if blk<nblk, else to DONE.
REQ-026 block SHALL equal blk in LOADWV, ROUND and ACCUM, and 0 in IDLE, INIT and DONE.
REQ-027 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 load_wv, round_en, accum, w_ready and done SHALL be 0 outside their stated states.
REQ-030 Latency SHALL be start cycle to done = 2 + 66*nblk cycles plus stall cycles (134 for nblk=2).
REQ-031 start while busy SHALL be ignored.
REQ-032 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no accum and no done; abort SHALL take priority over all other transitions.
REQ-033 round SHALL never exceed ROUNDS-1 and SHALL return to 0 on entry to LOADWV.

Reset
REQ-034 On rst=1 at a clock edge: state=IDLE, blk=0, nblk=1, round=0, and every output 0.
REQ-035 rst SHALL override abort and start, including when asserted mid-ROUND, leaving no partial accum.

Structure
REQ-036 Package sha256_pkg SHALL hold the state enum, ROUNDS, MSG_WORDS and the eight SHA-256 IV constants shared with the H accumulators.
REQ-037 One sub-module, sha256_round_cnt, SHALL be used: a 6-bit counter with clear, enable and a terminal-count flag.

Verification
REQ-038 Cover: rst, then start with num_blocks=2 and w_valid always 1 -> done exactly 134 cycles after the start edge; accum at cycles 67 and 133 with block=1 then block=2.
REQ-039 Cover: num_blocks=0 -> exactly one accum with block=1; done at cycle 68.
REQ-040 Cover: w_valid=0 for 5 cycles at round 7 -> round holds at 7, w_ready=0, done delayed by 5 cycles; a w_valid drop at round 20 has no effect.
REQ-041 Cover: abort at round 30 of block 2 -> IDLE next cycle, busy=0, no done; a following start completes normally.
REQ-042 Cover: rst mid-ROUND -> all outputs 0 next cycle; start pulses while busy -> no restart and latency unchanged.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 block sequencer shared types and constants.
// Round counts and the initial hash value used by the H accumulators.
package sha256_pkg;

  localparam int ROUNDS    = 64;
  localparam int MSG_WORDS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOADWV,
    S_ROUND,
    S_ACCUM,
    S_DONE
  } state_t;

  localparam logic [31:0] IV0 = 32'h6a09e667;
  localparam logic [31:0] IV1 = 32'hbb67ae85;
  localparam logic [31:0] IV2 = 32'h3c6ef372;
  localparam logic [31:0] IV3 = 32'ha54ff53a;
  localparam logic [31:0] IV4 = 32'h510e527f;
  localparam logic [31:0] IV5 = 32'h9b05688c;
  localparam logic [31:0] IV6 = 32'h1f83d9ab;
  localparam logic [31:0] IV7 = 32'h5be0cd19;

  // A zero block count still hashes one block.
  function automatic logic [1:0] blk_count(
    input logic [1:0] n
  );
    return (n == 2'd0) ? 2'd1 : n;
  endfunction

endpackage

// File: rtl/sha256_round_cnt.sv
// Round index counter for the SHA-256 sequencer.
// Wraps to zero after the terminal round.
module sha256_round_cnt #(
  parameter int ROUNDS = 64
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  output logic [5:0] cnt,
  output logic       tc
);

  assign tc = (cnt == 6'(ROUNDS - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= 6'd0;
    end else if (en) begin
      cnt <= tc ? 6'd0 : cnt + 6'd1;
    end
  end

endmodule

// File: rtl/sha256_block_seq.sv
// SHA-256 multi-block compression sequencer.
// Drives the word mux, working-variable and accumulator strobes.
module sha256_block_seq #(
  parameter int ROUNDS    = sha256_pkg::ROUNDS,
  parameter int MSG_WORDS = sha256_pkg::MSG_WORDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] num_blocks,
  input  logic       abort,
  input  logic       w_valid,
  output logic       w_ready,
  output logic [1:0] block,
  output logic [5:0] round,
  output logic       w_sel,
  output logic       load_wv,
  output logic       round_en,
  output logic       accum,
  output logic       busy,
  output logic       done
);

  import sha256_pkg::*;

  state_t     state;
  state_t     nxt;
  logic [1:0] blk;
  logic [1:0] nblk;
  logic       tc;
  logic       cnt_clr;
  logic       msg_phase;
  logic       kill;

  assign kill      = abort && (state != S_IDLE);
  assign msg_phase = (round < 6'(MSG_WORDS));
  assign cnt_clr   = rst || kill || (state != S_ROUND);

  sha256_round_cnt #(
    .ROUNDS (ROUNDS)
  ) u_cnt (
    .clk (clk),
    .clr (cnt_clr),
    .en  (round_en),
    .cnt (round),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk  <= 2'd0;
      nblk <= 2'd1;
    end else if (kill) begin
      blk  <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            nblk <= blk_count(num_blocks);
          end
        end
        S_INIT:  blk <= 2'd1;
        S_ACCUM: begin
          if (blk < nblk) begin
            blk <= blk + 2'd1;
          end
        end
        S_DONE:  blk <= 2'd0;
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start) nxt = S_INIT;
      S_INIT:   nxt = S_LOADWV;
      S_LOADWV: nxt = S_ROUND;
      S_ROUND:  if (round_en && tc) nxt = S_ACCUM;
      S_ACCUM:  nxt = (blk < nblk) ? S_LOADWV : S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    // Abort wins over every other transition.
    if (kill) begin
      nxt = S_IDLE;
    end
  end

  always_comb begin
    w_ready  = 1'b0;
    block    = 2'd0;
    w_sel    = 1'b0;
    load_wv  = 1'b0;
    round_en = 1'b0;
    accum    = 1'b0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_LOADWV: begin
        load_wv = 1'b1;
        block   = blk;
      end
      S_ROUND: begin
        block    = blk;
        w_sel    = !msg_phase;
        round_en = msg_phase ? w_valid : 1'b1;
        w_ready  = msg_phase && w_valid;
      end
      S_ACCUM: begin
        accum = 1'b1;
        block = blk;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sha256_block_seq.sv
// Directed bench for the SHA-256 block sequencer.
// Cycle 0 is the cycle in which start is high.
module tb_sha256_block_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] num_blocks;
  logic       abort;
  logic       w_valid;
  logic       w_ready;
  logic [1:0] block;
  logic [5:0] round;
  logic       w_sel;
  logic       load_wv;
  logic       round_en;
  logic       accum;
  logic       busy;
  logic       done;

  int passed = 0;
  int total  = 0;

  int         dc;
  int         nacc;
  int         hold;
  int         ld_c;
  int         acc_c [2];
  logic [1:0] acc_b [2];
  logic [5:0] ab_round;
  logic [1:0] ab_block;

  sha256_block_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_blocks (num_blocks),
    .abort      (abort),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .block      (block),
    .round      (round),
    .w_sel      (w_sel),
    .load_wv    (load_wv),
    .round_en   (round_en),
    .accum      (accum),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [14:0] outs();
    return {busy, done, load_wv, round_en, accum,
            w_ready, w_sel, block, round};
  endfunction

  task automatic run_hash(
    input logic [1:0] nb,
    input int         st_n,
    input int         ab_c,
    input bit         sp
  );
    int c;
    int stalled;
    bit dropped;
    c = 0;
    stalled = 0;
    dropped = 1'b0;
    dc = -1;
    nacc = 0;
    hold = 0;
    ld_c = -1;
    acc_c[0] = -1;
    acc_c[1] = -1;
    acc_b[0] = 2'd0;
    acc_b[1] = 2'd0;
    num_blocks = nb;
    w_valid = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step();
      c++;
      start = sp && (c == 5 || c == 90);
      w_valid = 1'b1;
      if (busy && !w_sel && round == 6'd7 && stalled < st_n) begin
        w_valid = 1'b0;
        stalled++;
      end
      if (busy && round == 6'd20 && !dropped) begin
        w_valid = 1'b0;
        dropped = 1'b1;
      end
      #1;
      if (!w_valid && round == 6'd7 && !w_ready && !round_en)
        hold++;
      if (load_wv && ld_c < 0)
        ld_c = c;
      if (accum) begin
        if (nacc < 2) begin
          acc_c[nacc] = c;
          acc_b[nacc] = block;
        end
        nacc++;
      end
      if (done) begin
        dc = c;
        break;
      end
      if (c == ab_c) begin
        ab_round = round;
        ab_block = block;
        abort = 1'b1;
      end else if (ab_c > 0 && c == ab_c + 1) begin
        abort = 1'b0;
        break;
      end
    end
    start = 1'b0;
    w_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    num_blocks = 2'd2;
    w_valid = 1'b1;
    step();
    step();
    chk("reset_outs", 32'(outs()), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    step();
    chk("reset_idle", 32'(busy), 32'd0);

    run_hash(2'd2, 0, 0, 1'b0);
    chk("b2_done_cyc", dc, 134);
    chk("b2_nacc", nacc, 2);
    chk("b2_acc0_cyc", acc_c[0], 67);
    chk("b2_acc1_cyc", acc_c[1], 133);
    chk("b2_acc0_blk", 32'(acc_b[0]), 1);
    chk("b2_acc1_blk", 32'(acc_b[1]), 2);
    chk("b2_loadwv_cyc", ld_c, 2);
    step();
    chk("b2_idle_after", 32'(outs()), 32'd0);

    run_hash(2'd0, 0, 0, 1'b0);
    chk("b0_done_cyc", dc, 68);
    chk("b0_nacc", nacc, 1);
    chk("b0_acc_blk", 32'(acc_b[0]), 1);
    chk("b0_acc_cyc", acc_c[0], 67);
    step();

    run_hash(2'd1, 5, 0, 1'b0);
    chk("stall_hold", hold, 5);
    chk("stall_acc_cyc", acc_c[0], 72);
    chk("stall_done_cyc", dc, 73);
    step();

    run_hash(2'd2, 0, 99, 1'b0);
    chk("abort_round", 32'(ab_round), 30);
    chk("abort_block", 32'(ab_block), 2);
    chk("abort_outs", 32'(outs()), 32'd0);
    chk("abort_nacc", nacc, 1);
    chk("abort_no_done", dc, -1);

    run_hash(2'd1, 0, 0, 1'b0);
    chk("post_abort_done", dc, 68);
    step();

    num_blocks = 2'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    chk("mid_round_en", 32'(round_en), 1);
    chk("mid_round_idx", 32'(round), 18);
    rst = 1'b1;
    abort = 1'b1;
    start = 1'b1;
    step();
    chk("mid_rst_outs", 32'(outs()), 32'd0);
    rst = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    step();
    chk("mid_rst_idle", 32'(outs()), 32'd0);

    run_hash(2'd2, 0, 0, 1'b1);
    chk("busy_start_done", dc, 134);
    chk("busy_start_nacc", nacc, 2);
    step();
    chk("busy_start_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
